// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default bit period.
// Also used by uart_rx.
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 16;

  // Encoding is shared with uart_rx, so values must stay stable.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_START  = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_PARITY = 3'd5;
  localparam logic [2:0] ST_STOP   = 3'd6;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: tick marks the last clk of each bit period.
// The count is held at zero while disabled and reloads on every tick.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || !en || tick) cnt <= '0;
    else                    cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter that pops bytes from an upstream FIFO and sends 8N1-style frames.
// When UART_TX_PARITY_EN is defined, an even-parity bit is inserted between the data and stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              txd,
  output logic              busy
);

  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  logic [2:0]        state;
  logic [DATA_W-1:0] shreg;
  logic [BW-1:0]     bit_idx;
  logic              tick;
  logic              bit_en;
`ifdef UART_TX_PARITY_EN
  logic              par;
`endif

  always_comb begin
    bit_en = 1'b0;
    case (state)
      ST_START, ST_DATA, ST_STOP: bit_en = 1'b1;
`ifdef UART_TX_PARITY_EN
      ST_PARITY:                  bit_en = 1'b1;
`endif
      default:                    bit_en = 1'b0;
    endcase
  end

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .en   (bit_en),
    .tick (tick)
  );

  // FETCH is entered only with data present; the empty gate keeps a stray pop impossible.
  assign fifo_rd = (state == ST_FETCH) && !fifo_empty && !rst;
  assign busy    = (state != ST_IDLE);

  // txd is registered alongside the state, so it always carries the level of the current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      txd     <= 1'b1;
      shreg   <= '0;
      bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (!fifo_empty) state <= ST_FETCH;
        ST_FETCH: state <= ST_LOAD;
        ST_LOAD: begin
          shreg <= fifo_dout;
`ifdef UART_TX_PARITY_EN
          par   <= ^fifo_dout;
`endif
          txd   <= 1'b0;
          state <= ST_START;
        end
        ST_START: if (tick) begin
          txd     <= shreg[0];
          bit_idx <= '0;
          state   <= ST_DATA;
        end
        ST_DATA: if (tick) begin
          if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            txd   <= par;
            state <= ST_PARITY;
`else
            txd   <= 1'b1;
            state <= ST_STOP;
`endif
          end else begin
            bit_idx <= bit_idx + 1'b1;
            shreg   <= {1'b0, shreg[DATA_W-1:1]};
            txd     <= shreg[1];
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: if (tick) begin
          txd   <= 1'b1;
          state <= ST_STOP;
        end
`endif
        ST_STOP: if (tick) state <= fifo_empty ? ST_IDLE : ST_FETCH;
        default: begin
          txd   <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
- REQ-001 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; legal range 2..65535.
- REQ-002 Parameter DATA_W, default 8: data bits per frame; legal range 5..8.
- REQ-003 Port clk, input, 1: single clock; all logic on its rising edge.
- REQ-004 Port rst, input, 1: reset, synchronous and active-high.
- REQ-005 Port fifo_empty, input, 1: upstream FIFO has no data when high.
- REQ-006 Port fifo_rd, output, 1: one-cycle pop strobe to upstream FIFO.
- REQ-007 Port fifo_dout, input, DATA_W: FIFO read data; valid on the cycle after fifo_rd is high.
- REQ-008 Port txd, output, 1: serial line; idle level 1.
- REQ-009 Port busy, output, 1: high from FETCH entry until the last stop-bit cycle completes.

Function
- REQ-010 The FSM SHALL have exactly these states: IDLE, FETCH, LOAD, START, DATA, [PARITY], STOP.
- REQ-011 IDLE: txd=1, busy=0, fifo_rd=0; go to FETCH on any edge where fifo_empty=0.
- REQ-012 FETCH: fifo_rd=1 for exactly one cycle; unconditionally go to LOAD.
- REQ-013 LOAD: capture fifo_dout into the shift register; go to START; fifo_rd=0.
- REQ-014 START: txd=0 for exactly CLKS_PER_BIT cycles.
- REQ-015 DATA: send DATA_W bits LSB first, each held exactly CLKS_PER_BIT cycles; a bit counter of width clog2(DATA_W) tracks the bit index.
- REQ-016 STOP: txd=1 for exactly CLKS_PER_BIT cycles; on the last cycle go to FETCH if fifo_empty=0, else IDLE.
- REQ-017 Back-to-back frames: at most 2 cycles of idle-level txd (FETCH, LOAD) between the stop bit and the next start bit.
- REQ-018 The baud counter SHALL reload at every bit boundary; it SHALL be width clog2(CLKS_PER_BIT) and never wrap mid-bit.
- REQ-019 fifo_rd SHALL never be asserted while fifo_empty=1 on that same cycle.
- REQ-020 fifo_empty changes during START/DATA/STOP SHALL have no effect on the current frame.
- REQ-021 txd SHALL be driven from a flop (glitch-free).

Reset
- REQ-022 When rst=1 at an edge: state=IDLE, txd=1, busy=0, fifo_rd=0, counters=0, shift register=0.
- REQ-023 A reset mid-frame SHALL abort the frame; txd=1 from the next edge; the aborted byte is not retransmitted.
- REQ-024 rst SHALL take priority over all other inputs.

Configuration
- REQ-025 Macro UART_TX_PARITY_EN defined: a PARITY state follows DATA, sending even parity (XOR of data bits) for CLKS_PER_BIT cycles; frame length is DATA_W+3 bits.
- REQ-026 Macro UART_TX_PARITY_EN undefined: the PARITY state and its logic are absent; DATA goes directly to STOP; frame length is DATA_W+2 bits.

Structure
- REQ-027 A shared package uart_pkg SHALL hold the FSM state encoding constants and the default CLKS_PER_BIT; the package is shared with the future uart_rx.
- REQ-028 One sub-module uart_baud_cnt (reload counter with tick output) SHALL be used; everything else stays in uart_tx.

Verification (CLKS_PER_BIT=4, DATA_W=8)
- REQ-029 rst held 2 cycles with fifo_empty=0 -> txd=1, fifo_rd=0, busy=0 throughout reset.
- REQ-030 Single byte 8'h03, FIFO then empty -> one fifo_rd pulse; txd sequence 0,1,1,0,0,0,0,0,0,1, each bit 4 cycles; then IDLE.
- REQ-031 Bytes 8'h07 and 8'h01 queued -> two frames; exactly 2 idle cycles between the stop bit and the second start bit; exactly 2 fifo_rd pulses.
- REQ-032 fifo_empty=1 forever after reset -> fifo_rd never asserted; txd stays 1.
- REQ-033 rst pulsed during bit 3 of byte 8'h05 -> txd=1 next edge; FSM in IDLE; next byte 8'h02 sent correctly.
- REQ-034 UART_TX_PARITY_EN defined, byte 8'h07 -> parity bit 1 after bit 7; frame is 11 bits (44 cycles).
